// File: rtl/or1k_cfgrs_spr_port.sv
// or1k_cfgrs_spr_port: group-0 SPR slave for configuration, version, ID and EVBAR registers
module or1k_cfgrs_spr_port #(
    parameter int unsigned OPTION_CORE_ID     = 0,
    parameter int unsigned OPTION_NUM_CORES   = 1,
    parameter logic [7:0]  OPTION_PIPELINE_ID = 8'd3,
    parameter int unsigned OPTION_RD_LATENCY  = 1,
    parameter string       FEATURE_EVBAR      = "NONE"
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst_n,
    input  logic [15:0] spr_bus_addr_i,
    input  logic        spr_bus_stb_i,
    input  logic        spr_bus_we_i,
    input  logic [31:0] spr_bus_dat_i,
    input  logic [31:0] cfg_vr_i,
    input  logic [31:0] cfg_vr2_i,
    input  logic [31:0] cfg_upr_i,
    input  logic [31:0] cfg_cpucfgr_i,
    input  logic [31:0] cfg_dmmucfgr_i,
    input  logic [31:0] cfg_immucfgr_i,
    input  logic [31:0] cfg_dccfgr_i,
    input  logic [31:0] cfg_iccfgr_i,
    input  logic [31:0] cfg_dcfgr_i,
    input  logic [31:0] cfg_pccfgr_i,
    input  logic [31:0] cfg_avr_i,
    output logic        spr_bus_ack_o,
    output logic [31:0] spr_bus_dat_o,
    output logic [31:0] spr_evbar_o
);
    localparam logic EVBAR_EN = (FEATURE_EVBAR != "NONE");
    localparam logic [1:0] CNT_LOAD = 2'(OPTION_RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK, WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        ack_d;
    logic        accept;
    logic [10:0] idx_q;
    logic        we_q;
    logic [31:0] wdat_q;
    logic [31:0] rdata;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [31:0] evbar_q;

    assign accept        = (state_q == IDLE) && spr_bus_stb_i && (spr_bus_addr_i[15:11] == 5'd0);
    assign spr_bus_ack_o = ack_q;
    assign spr_bus_dat_o = dat_q;
    assign spr_evbar_o   = evbar_q;

    // Handshake FSM: accept, count down the latency, ack once, wait for strobe release
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = BUSY;
                cnt_d   = CNT_LOAD;
            end
            BUSY: if (!spr_bus_stb_i) state_d = IDLE;
                  else if (cnt_q == 2'd0) begin
                      state_d = ACK;
                      ack_d   = 1'b1;
                  end else cnt_d = cnt_q - 2'd1;
            ACK:  state_d = WAIT;
            WAIT: if (!spr_bus_stb_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read map decoded from the latched index
    always_comb begin
        rdata = '0;
        case (idx_q)
            11'd0:   rdata = cfg_vr_i;
            11'd1:   rdata = cfg_upr_i;
            11'd2:   rdata = cfg_cpucfgr_i;
            11'd3:   rdata = cfg_dmmucfgr_i;
            11'd4:   rdata = cfg_immucfgr_i;
            11'd5:   rdata = cfg_dccfgr_i;
            11'd6:   rdata = cfg_iccfgr_i;
            11'd7:   rdata = cfg_dcfgr_i;
            11'd8:   rdata = cfg_pccfgr_i;
            11'd9:   rdata = (cfg_vr2_i & 32'hFFFF_FF00) | {24'd0, OPTION_PIPELINE_ID};
            11'd10:  rdata = cfg_avr_i;
            11'd11:  rdata = EVBAR_EN ? evbar_q : 32'd0;
            11'd128: rdata = 32'(OPTION_CORE_ID);
            11'd129: rdata = 32'(OPTION_NUM_CORES);
            default: rdata = '0;
        endcase
    end

    // State, request latch, registered response and EVBAR (low 13 bits forced to zero)
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            evbar_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= accept ? spr_bus_addr_i[10:0] : idx_q;
            we_q    <= accept ? spr_bus_we_i : we_q;
            wdat_q  <= accept ? (spr_bus_dat_i & 32'hFFFF_E000) : wdat_q;
            ack_q   <= ack_d;
            dat_q   <= (ack_d && !we_q) ? rdata : 32'd0;
            evbar_q <= (ack_d && we_q && EVBAR_EN && idx_q == 11'd11) ? wdat_q : evbar_q;
        end
    end
endmodule

// File: tb/tb_or1k_cfgrs_spr_port.sv
// tb_or1k_cfgrs_spr_port: three parameterisations on a shared bus, scoreboard-checked
module tb_or1k_cfgrs_spr_port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] wdat = '0;
    logic [31:0] cfg_vr = 32'h1000_0041, cfg_vr2 = 32'h0105_0AFF, cfg_upr = 32'h0000_0601;
    logic [31:0] cfg_cpu = 32'h0000_0420, cfg_dmmu = 32'h0000_0111, cfg_immu = 32'h0000_0222;
    logic [31:0] cfg_dc = 32'h0000_0333, cfg_ic = 32'h0000_0444, cfg_dcf = 32'h0000_0555;
    logic [31:0] cfg_pc = 32'h0000_0666, cfg_avr = 32'h0102_0300;
    logic [2:0]  ack;
    logic [31:0] dato [3];
    logic [31:0] evb [3];
    int total = 0;
    int bad = 0;

    typedef struct {int k; int lat; logic chk; logic [31:0] d;} exp_t;
    typedef struct {int lat; int n; logic [31:0] d;} obs_t;
    exp_t sq[$];
    obs_t ob[$];
    exp_t e;
    obs_t o;

    always #5 clk = ~clk;

    or1k_cfgrs_spr_port #(.OPTION_CORE_ID(2), .OPTION_NUM_CORES(4), .OPTION_PIPELINE_ID(8'h05),
        .OPTION_RD_LATENCY(1), .FEATURE_EVBAR("ENABLED")) dut_a (
        .cpu_clk(clk), .cpu_rst_n(rst_n), .spr_bus_addr_i(addr), .spr_bus_stb_i(stb),
        .spr_bus_we_i(we), .spr_bus_dat_i(wdat), .cfg_vr_i(cfg_vr), .cfg_vr2_i(cfg_vr2),
        .cfg_upr_i(cfg_upr), .cfg_cpucfgr_i(cfg_cpu), .cfg_dmmucfgr_i(cfg_dmmu),
        .cfg_immucfgr_i(cfg_immu), .cfg_dccfgr_i(cfg_dc), .cfg_iccfgr_i(cfg_ic),
        .cfg_dcfgr_i(cfg_dcf), .cfg_pccfgr_i(cfg_pc), .cfg_avr_i(cfg_avr),
        .spr_bus_ack_o(ack[0]), .spr_bus_dat_o(dato[0]), .spr_evbar_o(evb[0]));

    or1k_cfgrs_spr_port #(.OPTION_RD_LATENCY(4), .FEATURE_EVBAR("ENABLED")) dut_b (
        .cpu_clk(clk), .cpu_rst_n(rst_n), .spr_bus_addr_i(addr), .spr_bus_stb_i(stb),
        .spr_bus_we_i(we), .spr_bus_dat_i(wdat), .cfg_vr_i(cfg_vr), .cfg_vr2_i(cfg_vr2),
        .cfg_upr_i(cfg_upr), .cfg_cpucfgr_i(cfg_cpu), .cfg_dmmucfgr_i(cfg_dmmu),
        .cfg_immucfgr_i(cfg_immu), .cfg_dccfgr_i(cfg_dc), .cfg_iccfgr_i(cfg_ic),
        .cfg_dcfgr_i(cfg_dcf), .cfg_pccfgr_i(cfg_pc), .cfg_avr_i(cfg_avr),
        .spr_bus_ack_o(ack[1]), .spr_bus_dat_o(dato[1]), .spr_evbar_o(evb[1]));

    or1k_cfgrs_spr_port dut_c (
        .cpu_clk(clk), .cpu_rst_n(rst_n), .spr_bus_addr_i(addr), .spr_bus_stb_i(stb),
        .spr_bus_we_i(we), .spr_bus_dat_i(wdat), .cfg_vr_i(cfg_vr), .cfg_vr2_i(cfg_vr2),
        .cfg_upr_i(cfg_upr), .cfg_cpucfgr_i(cfg_cpu), .cfg_dmmucfgr_i(cfg_dmmu),
        .cfg_immucfgr_i(cfg_immu), .cfg_dccfgr_i(cfg_dc), .cfg_iccfgr_i(cfg_ic),
        .cfg_dcfgr_i(cfg_dcf), .cfg_pccfgr_i(cfg_pc), .cfg_avr_i(cfg_avr),
        .spr_bus_ack_o(ack[2]), .spr_bus_dat_o(dato[2]), .spr_evbar_o(evb[2]));

    // Expected results for dut_a, dut_b, dut_c of one transaction (lat -1 = no ack)
    function automatic void ex3(int l0, int l1, int l2, logic c, logic [31:0] d0, logic [31:0] d1, logic [31:0] d2);
        sq.push_back('{0, l0, c, d0});
        sq.push_back('{1, l1, c, d1});
        sq.push_back('{2, l2, c, d2});
    endfunction

    // One bus transaction with stb held for a bounded window; a2 replaces addr after accept
    task automatic run(input logic [15:0] a, input logic w, input logic [31:0] wd, input int abort_at, input logic [15:0] a2);
        int lat [3];
        int n [3];
        logic [31:0] rd [3];
        for (int k = 0; k < 3; k++) begin lat[k] = -1; n[k] = 0; rd[k] = '0; end
        @(negedge clk);
        addr = a; we = w; wdat = wd; stb = 1'b1;
        @(posedge clk);
        #1 addr = a2;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++)
                if (ack[k]) begin
                    n[k]++;
                    if (lat[k] < 0) begin lat[k] = c; rd[k] = dato[k]; end
                end
            if (c == abort_at) stb = 1'b0;
        end
        stb = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) ob.push_back('{lat[k], n[k], rd[k]});
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stb = 1'b1; addr = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (ack !== 3'b000) begin bad++; $display("FAIL reset_ack got %b want 000", ack); end
        total++; if ((dato[0] | dato[1] | dato[2]) !== 32'd0) begin bad++; $display("FAIL reset_dat got %h %h %h want 0", dato[0], dato[1], dato[2]); end
        total++; if ((evb[0] | evb[1] | evb[2]) !== 32'd0) begin bad++; $display("FAIL reset_evbar got %h %h %h want 0", evb[0], evb[1], evb[2]); end
        @(negedge clk);
        stb = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        ex3(1, 4, 1, 1'b1, 32'h1000_0041, 32'h1000_0041, 32'h1000_0041);
        run(16'd0, 1'b0, 32'd0, 0, 16'd0);
        @(negedge clk);
        addr = 16'd11; we = 1'b1; wdat = 32'hFFFF_FFFF; stb = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        total++; if (ack[0] !== 1'b1) begin bad++; $display("FAIL midrst_pre_ack got %b want 1", ack[0]); end
        rst_n = 1'b0;
        #1;
        total++; if (ack !== 3'b000) begin bad++; $display("FAIL midrst_ack got %b want 000", ack); end
        total++; if ((evb[0] | evb[1]) !== 32'd0) begin bad++; $display("FAIL midrst_evbar got %h %h want 0", evb[0], evb[1]); end
        @(negedge clk);
        stb = 1'b0; rst_n = 1'b1;
        repeat (2) @(posedge clk);
        while (sq.size() > 0 && ob.size() > 0) begin
            e = sq.pop_front(); o = ob.pop_front();
            total++; if (o.lat !== e.lat || o.n !== (e.lat > 0 ? 1 : 0)) begin bad++; $display("FAIL reset_lat dut%0d got lat=%0d acks=%0d want lat=%0d", e.k, o.lat, o.n, e.lat); end
            if (e.chk) begin total++; if (o.d !== e.d) begin bad++; $display("FAIL reset_dat dut%0d got %h want %h", e.k, o.d, e.d); end end
        end
    endtask

    task automatic test_id_regs;
        ex3(1, 4, 1, 1'b1, 32'h0105_0A05, 32'h0105_0A03, 32'h0105_0A03);
        run(16'd9, 1'b0, 32'd0, 0, 16'd9);
        ex3(1, 4, 1, 1'b1, 32'd2, 32'd0, 32'd0);
        run(16'd128, 1'b0, 32'd0, 0, 16'd128);
        ex3(1, 4, 1, 1'b1, 32'd4, 32'd1, 32'd1);
        run(16'd129, 1'b0, 32'd0, 0, 16'd129);
        while (sq.size() > 0 && ob.size() > 0) begin
            e = sq.pop_front(); o = ob.pop_front();
            total++; if (o.lat !== e.lat || o.n !== (e.lat > 0 ? 1 : 0)) begin bad++; $display("FAIL id_lat dut%0d got lat=%0d acks=%0d want lat=%0d", e.k, o.lat, o.n, e.lat); end
            if (e.chk) begin total++; if (o.d !== e.d) begin bad++; $display("FAIL id_dat dut%0d got %h want %h", e.k, o.d, e.d); end end
        end
    endtask

    task automatic test_evbar;
        ex3(1, 4, 1, 1'b0, 32'd0, 32'd0, 32'd0);
        run(16'd11, 1'b1, 32'hDEAD_BEEF, 0, 16'd11);
        total++; if (evb[0] !== 32'hDEAD_A000) begin bad++; $display("FAIL evbar_a got %h want dead_a000", evb[0]); end
        total++; if (evb[1] !== 32'hDEAD_A000) begin bad++; $display("FAIL evbar_b got %h want dead_a000", evb[1]); end
        total++; if (evb[2] !== 32'd0) begin bad++; $display("FAIL evbar_none got %h want 0", evb[2]); end
        ex3(1, 4, 1, 1'b1, 32'hDEAD_A000, 32'hDEAD_A000, 32'd0);
        run(16'd11, 1'b0, 32'd0, 0, 16'd11);
        ex3(1, 4, 1, 1'b1, 32'h1000_0041, 32'h1000_0041, 32'h1000_0041);
        run(16'd0, 1'b0, 32'd0, 0, 16'd0);
        total++; if (evb[2] !== 32'd0) begin bad++; $display("FAIL evbar_none_after got %h want 0", evb[2]); end
        while (sq.size() > 0 && ob.size() > 0) begin
            e = sq.pop_front(); o = ob.pop_front();
            total++; if (o.lat !== e.lat || o.n !== (e.lat > 0 ? 1 : 0)) begin bad++; $display("FAIL evbar_lat dut%0d got lat=%0d acks=%0d want lat=%0d", e.k, o.lat, o.n, e.lat); end
            if (e.chk) begin total++; if (o.d !== e.d) begin bad++; $display("FAIL evbar_dat dut%0d got %h want %h", e.k, o.d, e.d); end end
        end
    endtask

    task automatic test_latency_abort;
        ex3(1, -1, 1, 1'b0, 32'd0, 32'd0, 32'd0);
        run(16'd11, 1'b1, 32'h1234_5678, 2, 16'd11);
        total++; if (evb[1] !== 32'hDEAD_A000) begin bad++; $display("FAIL abort_evbar_b got %h want dead_a000", evb[1]); end
        total++; if (evb[0] !== 32'h1234_4000) begin bad++; $display("FAIL abort_evbar_a got %h want 1234_4000", evb[0]); end
        ex3(1, 4, 1, 1'b1, 32'h1234_4000, 32'hDEAD_A000, 32'd0);
        run(16'd11, 1'b0, 32'd0, 0, 16'd11);
        while (sq.size() > 0 && ob.size() > 0) begin
            e = sq.pop_front(); o = ob.pop_front();
            total++; if (o.lat !== e.lat || o.n !== (e.lat > 0 ? 1 : 0)) begin bad++; $display("FAIL abort_lat dut%0d got lat=%0d acks=%0d want lat=%0d", e.k, o.lat, o.n, e.lat); end
            if (e.chk) begin total++; if (o.d !== e.d) begin bad++; $display("FAIL abort_dat dut%0d got %h want %h", e.k, o.d, e.d); end end
        end
    endtask

    task automatic test_unmapped;
        ex3(-1, -1, -1, 1'b0, 32'd0, 32'd0, 32'd0);
        run(16'h0800, 1'b0, 32'd0, 0, 16'h0800);
        ex3(-1, -1, -1, 1'b0, 32'd0, 32'd0, 32'd0);
        run(16'h080B, 1'b1, 32'hFFFF_FFFF, 0, 16'h080B);
        total++; if (evb[0] !== 32'h1234_4000) begin bad++; $display("FAIL grp1_write_evbar got %h want 1234_4000", evb[0]); end
        ex3(1, 4, 1, 1'b1, 32'd0, 32'd0, 32'd0);
        run(16'd50, 1'b0, 32'd0, 0, 16'd50);
        ex3(1, 4, 1, 1'b1, 32'd0, 32'd0, 32'd0);
        run(16'd21, 1'b0, 32'd0, 0, 16'd21);
        ex3(1, 4, 1, 1'b1, 32'h0102_0300, 32'h0102_0300, 32'h0102_0300);
        run(16'd10, 1'b0, 32'd0, 0, 16'd10);
        while (sq.size() > 0 && ob.size() > 0) begin
            e = sq.pop_front(); o = ob.pop_front();
            total++; if (o.lat !== e.lat || o.n !== (e.lat > 0 ? 1 : 0)) begin bad++; $display("FAIL unmapped_lat dut%0d got lat=%0d acks=%0d want lat=%0d", e.k, o.lat, o.n, e.lat); end
            if (e.chk) begin total++; if (o.d !== e.d) begin bad++; $display("FAIL unmapped_dat dut%0d got %h want %h", e.k, o.d, e.d); end end
        end
    endtask

    task automatic test_back_to_back;
        ex3(1, 4, 1, 1'b1, 32'h0000_0420, 32'h0000_0420, 32'h0000_0420);
        run(16'd2, 1'b0, 32'd0, 0, 16'd2);
        ex3(1, 4, 1, 1'b1, 32'h0000_0666, 32'h0000_0666, 32'h0000_0666);
        run(16'd8, 1'b0, 32'd0, 0, 16'd8);
        ex3(1, 4, 1, 1'b1, 32'h0000_0601, 32'h0000_0601, 32'h0000_0601);
        run(16'd1, 1'b0, 32'd0, 0, 16'd8);
        while (sq.size() > 0 && ob.size() > 0) begin
            e = sq.pop_front(); o = ob.pop_front();
            total++; if (o.lat !== e.lat || o.n !== (e.lat > 0 ? 1 : 0)) begin bad++; $display("FAIL b2b_lat dut%0d got lat=%0d acks=%0d want lat=%0d", e.k, o.lat, o.n, e.lat); end
            if (e.chk) begin total++; if (o.d !== e.d) begin bad++; $display("FAIL b2b_dat dut%0d got %h want %h", e.k, o.d, e.d); end end
        end
    endtask

    initial begin
        test_reset;
        test_id_regs;
        test_evbar;
        test_latency_abort;
        test_unmapped;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
